// File: rtl/aes_req_arb.sv
// Purpose: round-robin arbiter/sequencer sharing one AES core between N_REQ requesters.
// Latency: accept -> ISSUE -> WAIT (1..TIMEOUT) -> RESP; NOOP/unknown go accept -> RESP.
// Backpressure: one operation in flight; req_ready_o is low outside IDLE so requesters hold valid.

package aes_pkg;
  localparam int OPW = 3;
  typedef logic [OPW-1:0] opcode;
  localparam opcode NOOP            = 3'd0;
  localparam opcode AESENC          = 3'd1;
  localparam opcode AESENCLAST      = 3'd2;
  localparam opcode AESENCFULL      = 3'd3;
  localparam opcode AESKEYGENASSIST = 3'd4;
endpackage

module aes_req_arb #(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 31,
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*aes_pkg::OPW-1:0] req_opcode_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic                          core_start_o,
  output logic [aes_pkg::OPW-1:0]       core_opcode_o,
  output logic [IW-1:0]                 core_sel_o,
  input  logic                          core_cipher_ready_i,
  input  logic                          core_key_ready_i,
  output logic [N_REQ-1:0]              rsp_valid_o,
  output logic                          rsp_err_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                  r_state, w_state_nxt;
  logic [IW-1:0]           r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]           r_grant, w_grant_nxt;
  logic [aes_pkg::OPW-1:0] r_op, w_op_nxt;
  logic [7:0]              r_timer, w_timer_nxt;
  logic                    r_err, w_err_nxt;

  logic [IW-1:0]           w_idx, w_pick;
  logic                    w_any;
  logic [aes_pkg::OPW-1:0] w_req_op;
  logic                    w_req_key, w_req_cip;
  logic                    w_op_key, w_op_cip;
  logic                    w_exp_flag, w_bad_flag;

  // Round-robin search: lowest offset from rr_ptr (with wrap) whose request is valid.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (req_valid_i[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Opcode decode for the candidate request and for the latched operation.
  always_comb begin
    w_req_op   = req_opcode_i[int'(w_pick)*aes_pkg::OPW +: aes_pkg::OPW];
    w_req_key  = (w_req_op == aes_pkg::AESKEYGENASSIST);
    w_req_cip  = (w_req_op == aes_pkg::AESENC) || (w_req_op == aes_pkg::AESENCLAST) ||
                 (w_req_op == aes_pkg::AESENCFULL);
    w_op_key   = (r_op == aes_pkg::AESKEYGENASSIST);
    w_op_cip   = (r_op == aes_pkg::AESENC) || (r_op == aes_pkg::AESENCLAST) ||
                 (r_op == aes_pkg::AESENCFULL);
    // When both flags arrive together the expected one wins.
    w_exp_flag = (w_op_key & core_key_ready_i) | (w_op_cip & core_cipher_ready_i);
    w_bad_flag = (w_op_key & core_cipher_ready_i) | (w_op_cip & core_key_ready_i);
  end

  // Next-state and output decode; ready pulses outside WAIT are simply not looked at.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_grant_nxt   = r_grant;
    w_op_nxt      = r_op;
    w_timer_nxt   = r_timer;
    w_err_nxt     = r_err;
    req_ready_o   = '0;
    core_start_o  = 1'b0;
    core_opcode_o = aes_pkg::NOOP;
    core_sel_o    = r_grant;
    rsp_valid_o   = '0;
    rsp_err_o     = 1'b0;
    busy_o        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          // Gated by reset so every output is quiet while nrst is low.
          req_ready_o[w_pick] = nrst;
          w_grant_nxt         = w_pick;
          w_op_nxt            = w_req_op;
          if (w_req_key || w_req_cip) begin
            w_state_nxt = S_ISSUE;
            w_err_nxt   = 1'b0;
          end else begin
            // NOOP completes cleanly; any unknown encoding is rejected without touching the core.
            w_state_nxt = S_RESP;
            w_err_nxt   = (w_req_op != aes_pkg::NOOP);
          end
        end
      end
      S_ISSUE: begin
        core_start_o  = 1'b1;
        core_opcode_o = r_op;
        w_timer_nxt   = '0;
        w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        core_opcode_o = r_op;
        w_timer_nxt   = r_timer + 8'd1;
        // r_timer counts completed WAIT cycles, so TIMEOUT-1 marks the last allowed one.
        if (w_exp_flag) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b0;
        end else if (w_bad_flag || (r_timer == 8'(TIMEOUT - 1))) begin
          w_state_nxt = S_RESP;
          w_err_nxt   = 1'b1;
        end
      end
      S_RESP: begin
        core_opcode_o       = r_op;
        rsp_valid_o[r_grant] = 1'b1;
        rsp_err_o           = r_err;
        w_rr_ptr_nxt        = (r_grant == IW'(N_REQ - 1)) ? '0 : r_grant + IW'(1);
        w_state_nxt         = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and operation registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_op     <= aes_pkg::NOOP;
      r_timer  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_op     <= w_op_nxt;
      r_timer  <= w_timer_nxt;
      r_err    <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_aes_req_arb.sv
// Purpose: randomized and directed checking of aes_req_arb against a transaction-level model.
// Latency: model predicts the response cycle from the planned core-ready delay at acceptance.
// Backpressure: requesters hold valid/opcode until ready; the bench plays the AES core.

module tb_aes_req_arb;
  localparam int N  = 4;
  localparam int TO = 31;
  localparam logic [2:0] NOOP = 3'd0, ENC = 3'd1, ENCL = 3'd2, ENCF = 3'd3, KGA = 3'd4;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] req_valid_i;
  logic [N*3-1:0] req_opcode_i;
  logic [N-1:0] req_ready_o;
  logic         core_start_o;
  logic [2:0]   core_opcode_o;
  logic [1:0]   core_sel_o;
  logic         core_cipher_ready_i, core_key_ready_i;
  logic [N-1:0] rsp_valid_o;
  logic         rsp_err_o, busy_o;

  aes_req_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst), .req_valid_i(req_valid_i), .req_opcode_i(req_opcode_i),
    .req_ready_o(req_ready_o), .core_start_o(core_start_o), .core_opcode_o(core_opcode_o),
    .core_sel_o(core_sel_o), .core_cipher_ready_i(core_cipher_ready_i),
    .core_key_ready_i(core_key_ready_i), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Stimulus state
  logic [N-1:0] vld;
  logic [2:0]   opc [N];
  bit           key_at [int];
  bit           cip_at [int];
  int  fix_d, fix_kind;
  bit  keep_req, rand_req, strays;

  // Reference model: one operation window [act_acc, act_rsp] plus the round-robin pointer.
  int       cyc, ptr, act_acc, act_start, act_rsp, act_grant;
  logic [2:0] act_op;
  bit       act_err;

  // Observations of the DUT for directed summaries
  int obs_grants [$];
  int n_starts, n_rsp, n_busy, last_start_cyc, last_rsp_cyc, last_grant;
  logic last_err;
  logic [N-1:0] last_rsp_vec;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, req_ready_o, 0);
    chk({tag, "_start"}, core_start_o, 0);
    chk({tag, "_opcode"}, core_opcode_o, NOOP);
    chk({tag, "_sel"}, core_sel_o, 0);
    chk({tag, "_rsp"}, rsp_valid_o, 0);
    chk({tag, "_err"}, rsp_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic model_reset();
    ptr = 0; act_acc = -10; act_start = -1; act_rsp = -1;
    key_at.delete(); cip_at.delete();
  endtask

  function automatic logic [2:0] rand_op();
    case ($urandom_range(0, 9))
      0: return NOOP;
      1, 2, 9: return ENC;
      3: return ENCL;
      4: return ENCF;
      5, 6: return KGA;
      7: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // Plan the core's answer for an accepted request and derive when/how the DUT must respond.
  task automatic accept(input int g);
    int d, kind, t;
    bit want_key;
    act_acc = cyc; act_grant = g; act_op = opc[g];
    if (act_op inside {ENC, ENCL, ENCF, KGA}) begin
      act_start = cyc + 1;
      if (fix_d > 0) begin
        d = fix_d; kind = fix_kind;
      end else begin
        t = $urandom_range(0, 19);
        if (t == 0)     d = TO + $urandom_range(1, 3);
        else if (t < 5) d = $urandom_range(5, 12);
        else            d = $urandom_range(1, 4);
        kind = $urandom_range(0, 2);   // 0 expected, 1 wrong flag, 2 both
      end
      if (d <= TO) begin
        act_rsp = act_start + d + 1; act_err = (kind == 1);
      end else begin
        act_rsp = act_start + TO + 1; act_err = 1'b1;
      end
      want_key = (act_op == KGA);
      t = act_start + d;
      if (kind != 1) begin if (want_key) key_at[t] = 1'b1; else cip_at[t] = 1'b1; end
      if (kind != 0) begin if (want_key) cip_at[t] = 1'b1; else key_at[t] = 1'b1; end
    end else begin
      act_start = -1; act_rsp = cyc + 1; act_err = (act_op != NOOP);
    end
  endtask

  task automatic observe();
    for (int i = 0; i < N; i++)
      if (req_ready_o[i]) begin obs_grants.push_back(i); last_grant = i; end
    if (core_start_o) begin n_starts++; last_start_cyc = cyc; end
    if (rsp_valid_o != '0) begin
      n_rsp++; last_rsp_cyc = cyc; last_err = rsp_err_o; last_rsp_vec = rsp_valid_o;
    end
    if (busy_o) n_busy++;
  endtask

  task automatic prep_next();
    if (rand_req)
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(0, 3) == 0) begin vld[i] = 1'b1; opc[i] = rand_op(); end
        end else if ($urandom_range(0, 39) == 0) vld[i] = 1'b0;
      end
    // Stray core pulses only where the model says nobody is waiting for one.
    if (strays && !(act_start >= 0 && cyc + 1 > act_start && cyc + 1 < act_rsp) &&
        $urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 1) cip_at[cyc + 1] = 1'b1; else key_at[cyc + 1] = 1'b1;
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy, exp_rsp;
    int g;
    @(posedge clk);
    cyc++;
    #1;
    req_valid_i = vld;
    for (int i = 0; i < N; i++) req_opcode_i[i*3 +: 3] = opc[i];
    core_key_ready_i    = key_at.exists(cyc);
    core_cipher_ready_i = cip_at.exists(cyc);
    @(negedge clk);
    if (!nrst) begin
      chk_zero("in_reset");
      model_reset();
      return;
    end
    exp_rdy = '0; exp_rsp = '0; g = -1;
    if (cyc > act_acc && cyc <= act_rsp) begin
      chk("busy", busy_o, 1);
      chk("start", core_start_o, (cyc == act_start));
      chk("opcode", core_opcode_o, act_op);
      chk("sel", core_sel_o, act_grant);
      if (cyc == act_rsp) begin
        exp_rsp[act_grant] = 1'b1;
        chk("rsp_err", rsp_err_o, act_err);
        ptr = (act_grant + 1) % N;
      end
    end else begin
      chk("busy_idle", busy_o, 0);
      chk("start_idle", core_start_o, 0);
      chk("opcode_idle", core_opcode_o, NOOP);
      for (int k = 0; k < N; k++)
        if (g < 0 && vld[(ptr + k) % N]) g = (ptr + k) % N;
      if (g >= 0) begin exp_rdy[g] = 1'b1; accept(g); end
    end
    chk("req_ready", req_ready_o, exp_rdy);
    chk("rsp_valid", rsp_valid_o, exp_rsp);
    observe();
    if (g >= 0 && !keep_req) vld[g] = 1'b0;
    prep_next();
  endtask

  task automatic reset_pulse();
    nrst = 1'b0;
    step(); step();
    nrst = 1'b1;
  endtask

  initial begin
    int s0, r0, b0;
    int ord4 [5];
    int ord2 [2];
    ord4 = '{0, 1, 2, 3, 0};
    ord2 = '{1, 3};
    nrst = 1'b0; vld = '0; req_valid_i = '0; req_opcode_i = '0;
    core_cipher_ready_i = 1'b0; core_key_ready_i = 1'b0;
    for (int i = 0; i < N; i++) opc[i] = NOOP;
    fix_d = 0; fix_kind = 0; keep_req = 0; rand_req = 0; strays = 0;
    cyc = 0; n_starts = 0; n_rsp = 0; n_busy = 0; last_grant = -1;
    last_start_cyc = 0; last_rsp_cyc = 0; last_err = 1'b0; last_rsp_vec = '0;
    model_reset();
    step(); step();
    nrst = 1'b1;

    // Single AESENC from requester 2, cipher ready 3 cycles after start.
    vld[2] = 1'b1; opc[2] = ENC; fix_d = 3; fix_kind = 0; s0 = n_starts;
    repeat (8) step();
    chk("t1_grant", last_grant, 2);
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_rsp_after_start", last_rsp_cyc - last_start_cyc, 4);

    // Everyone requesting continuously: strict rotation from pointer 0.
    reset_pulse();
    obs_grants.delete();
    for (int i = 0; i < N; i++) begin vld[i] = 1'b1; opc[i] = ENC; end
    keep_req = 1; fix_d = 2;
    repeat (24) step();
    keep_req = 0; vld = '0;
    repeat (6) step();
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order_%0d", i), (i < obs_grants.size()) ? obs_grants[i] : -1, ord4[i]);

    reset_pulse();
    obs_grants.delete();
    vld[3] = 1'b1; vld[1] = 1'b1; opc[3] = ENC; opc[1] = ENC;
    repeat (12) step();
    for (int i = 0; i < 2; i++)
      chk($sformatf("pair_order_%0d", i), (i < obs_grants.size()) ? obs_grants[i] : -1, ord2[i]);

    // Key-gen op answered with the cipher flag, then a correctly answered op.
    vld[0] = 1'b1; opc[0] = KGA; fix_d = 2; fix_kind = 1;
    repeat (6) step();
    chk("kga_wrong_err", last_err, 1);
    chk("kga_wrong_vec", last_rsp_vec, 4'b0001);
    vld[1] = 1'b1; opc[1] = ENC; fix_kind = 0;
    repeat (6) step();
    chk("after_err_err", last_err, 0);
    chk("after_err_vec", last_rsp_vec, 4'b0010);

    // Timeout, with a stray cipher pulse two cycles after the error response.
    vld[0] = 1'b1; opc[0] = ENC; fix_d = TO + 3; fix_kind = 0; r0 = n_rsp;
    repeat (TO + 8) step();
    chk("to_wait_cycles", last_rsp_cyc - last_start_cyc - 1, TO);
    chk("to_err", last_err, 1);
    chk("to_rsp_count", n_rsp - r0, 1);

    // NOOP: straight to response, core untouched.
    vld[1] = 1'b1; opc[1] = NOOP; s0 = n_starts; r0 = n_rsp; b0 = n_busy;
    repeat (4) step();
    chk("noop_starts", n_starts - s0, 0);
    chk("noop_busy_cycles", n_busy - b0, 1);
    chk("noop_rsp_count", n_rsp - r0, 1);
    chk("noop_vec", last_rsp_vec, 4'b0010);
    chk("noop_err", last_err, 0);

    // Reset during WAIT: outputs drop at once, no response, pointer back to 0.
    vld[2] = 1'b1; opc[2] = ENC; fix_d = 20;
    repeat (4) step();
    chk("pre_rst_busy", busy_o, 1);
    #2 nrst = 1'b0;
    #1 chk_zero("async_rst");
    r0 = n_rsp;
    step(); step();
    nrst = 1'b1;
    chk("rst_no_rsp", n_rsp - r0, 0);
    obs_grants.delete();
    for (int i = 0; i < N; i++) begin vld[i] = 1'b1; opc[i] = ENC; end
    fix_d = 2;
    step();
    chk("post_rst_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : -1, 0);
    vld = '0;
    repeat (8) step();

    // Randomized traffic with random core timing, wrong flags, timeouts and stray pulses.
    fix_d = 0; rand_req = 1; strays = 1;
    repeat (3000) step();
    rand_req = 0; strays = 0; vld = '0;
    repeat (50) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
